// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the
// sequential restoring divider.
package div_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

  // Step-counter width; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/resta_paso.sv
// Combinational W-bit subtractor: difference plus
// borrow taken from the top bit of the result.
module resta_paso #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-2:0] o_diff,
  output logic         o_borrow
);

  logic [W-1:0] w_full;

  assign w_full   = i_a - i_b;
  assign o_diff   = w_full[W-2:0];
  assign o_borrow = w_full[W-1];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit
// per clock, start/busy/done handshake.
module div_seq
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = cnt_w(N);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  // Dividend register; vacated LSBs collect
  // the quotient bits as the dividend shifts out.
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic          r_dz;

  logic [N:0]    w_rem_sh;
  logic [N-1:0]  w_diff;
  logic          w_borrow;
  logic [N-1:0]  w_rem_nx;
  logic [N-1:0]  w_quo_nx;

  assign w_rem_sh = {r_rem, r_dvd[N-1]};

  resta_paso #(.W(N+1)) u_sub (
    .i_a      (w_rem_sh),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_rem_nx = w_borrow ? w_rem_sh[N-1:0] : w_diff;
  assign w_quo_nx = {r_dvd[N-2:0], ~w_borrow};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start)
          w_next = (B == '0) ? FIN : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) w_next = FIN;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, shift-subtract steps, result load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd <= A;
            r_dvs <= B;
            r_rem <= '0;
            r_cnt <= CW'(N-1);
            r_dz  <= (B == '0);
            if (B == '0) begin
              r_q <= '1;
              r_r <= A;
            end
          end
        end
        CALC: begin
          r_dvd <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_q <= w_quo_nx;
            r_r <= w_rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign Q        = r_q;
  assign R        = r_r;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table,
// corner sequences, random ops and a full sweep.
module tb_div_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div_zero;

  always #5 clk = ~clk;

  div_seq #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Reference: plain arithmetic division.
  function automatic void ref_div(
    input int a, input int b,
    output int q, output int r, output bit dz);
    if (b == 0) begin
      q = (1 << N) - 1; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Issue one op from IDLE (at a negedge) and wait
  // for done. edges counts the accepting edge too.
  task automatic run_op(input logic [3:0] a,
                        input logic [3:0] b,
                        input bit hold,
                        output int edges,
                        output int nbusy,
                        output bit tmo);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    edges = 1;
    nbusy = busy ? 1 : 0;
    while (!done && edges < 20) begin
      @(negedge clk);
      edges++;
      if (busy) nbusy++;
    end
    tmo = !done;
  endtask

  task automatic check_op(input string nm,
                          input logic [3:0] a,
                          input logic [3:0] b);
    int ed, nb, q, r;
    bit tmo, dz;
    ref_div(a, b, q, r, dz);
    run_op(a, b, 1'b0, ed, nb, tmo);
    chk({nm, ".timeout"}, tmo, 0);
    chk({nm, ".lat"}, ed, dz ? 1 : N + 1);
    chk({nm, ".busy"}, nb, dz ? 0 : N);
    chk({nm, ".qrz"}, {Q, R, div_zero},
        {q[3:0], r[3:0], dz});
    @(negedge clk);
    chk({nm, ".idle"},
        {done, busy, Q, R, div_zero},
        {1'b0, 1'b0, q[3:0], r[3:0], dz});
  endtask

  task automatic count_done(input int cyc,
                            output int cnt);
    cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int ed, nb, q, r, cnt;
    bit tmo, dz;
    logic [3:0] ra, rb;

    tbl[0] = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0};
    tbl[1] = '{4'b1111, 4'b0001, 4'b1111, 4'b0000, 1'b0};
    tbl[2] = '{4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0};
    tbl[3] = '{4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[4] = '{4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b1};
    tbl[5] = '{4'b1011, 4'b0011, 4'b0011, 4'b0010, 1'b0};
    tbl[6] = '{4'b0010, 4'b1001, 4'b0000, 4'b0010, 1'b0};

    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", {Q, R, busy, done, div_zero}, '0);
    reset = 1'b0;

    // Table vectors; entry 5 follows the divide by
    // zero and must clear div_zero.
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0, ed, nb, tmo);
      chk("tbl.timeout", tmo, 0);
      chk("tbl.lat", ed, tbl[i].dz ? 1 : N + 1);
      chk("tbl.busy", nb, tbl[i].dz ? 0 : N);
      chk("tbl.qrz", {Q, R, div_zero},
          {tbl[i].q, tbl[i].r, tbl[i].dz});
      @(negedge clk);
      chk("tbl.pulse", {done, busy}, 2'b00);
    end

    // start during CALC must be ignored.
    A = 4'b1010; B = 4'b0011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'b1111; B = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ed = 3;
    while (!done && ed < 20) begin
      @(negedge clk);
      ed++;
    end
    chk("ign.timeout", !done, 0);
    chk("ign.lat", ed, N + 1);
    chk("ign.qr", {Q, R}, {4'b0011, 4'b0001});
    count_done(8, cnt);
    chk("ign.nodone", cnt, 0);

    // Reset on the 2nd CALC edge.
    A = 4'b1101; B = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.clr", {Q, R, busy, done, div_zero}, '0);
    reset = 1'b0;
    count_done(8, cnt);
    chk("rst.nodone", cnt, 0);
    check_op("rst.again", 4'b1101, 4'b0010);

    // Reset and start on the same edge.
    A = 4'b1001; B = 4'b0000;
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("rst.start", {Q, R, busy, done, div_zero}, '0);
    count_done(4, cnt);
    chk("rst.start.nodone", cnt, 0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      check_op("rand", ra, rb);
    end

    // Full sweep with start held high.
    for (int i = 0; i < 256; i++) begin
      ra = 4'(i >> 4);
      rb = 4'(i);
      ref_div(ra, rb, q, r, dz);
      run_op(ra, rb, 1'b1, ed, nb, tmo);
      if (tmo) begin
        chk("sweep.timeout", tmo, 0);
      end else begin
        chk("sweep.res",
            {(rb == 0) ? 1'b1 :
              ((32'(Q) * 32'(rb) + 32'(R) == 32'(ra))
               && (R < rb)),
             Q, R, div_zero},
            {1'b1, q[3:0], r[3:0], dz});
      end
      @(negedge clk);
      chk("sweep.gap", {done, busy}, 2'b00);
    end
    start = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
